// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: shifts the operand one bit per clock, logical or arithmetic,
// and reports completion with a single-cycle done pulse.
module shift_right_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               arith,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   inData,
    output logic [WIDTH-1:0]   outData,
    output logic               busy,
    output logic               done
);

    if (2 ** SHAMT_W != WIDTH) begin : gen_width_check
        $error("shift_right_seq: 2**SHAMT_W must equal WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic               mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            outData <= '0;
            cnt     <= '0;
            mode    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        outData <= inData;
                        cnt     <= shamt;
                        mode    <= arith;
                        busy    <= 1'b1;
                        state   <= StShift;
                    end
                end
                StShift: begin
                    if (cnt != '0) begin
                        // mode selects sign fill (SRA) versus zero fill (SRL)
                        outData <= {mode & outData[WIDTH-1], outData[WIDTH-1:1]};
                        cnt     <= cnt - SHAMT_W'(1);
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 Parameter: WIDTH, 32, data width of inData, outData and the working register.
REQ-002 Parameter: SHAMT_W, 5, width of shamt; the module SHALL require 2**SHAMT_W == WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 arith  input  1  1 = arithmetic shift (SRA, sign fill); 0 = logical shift (SRL, zero fill).
REQ-007 shamt  input  SHAMT_W  shift amount, 0..WIDTH-1, unsigned.
REQ-008 inData  input  WIDTH  operand.
REQ-009 outData  output  WIDTH  working register; holds the result while done=1 and until the next accepted start.
REQ-010 busy  output  1  high while in SHIFT.
REQ-011 done  output  1  one-cycle pulse; result valid.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE, with registered outputs only.
REQ-013 IDLE: on an edge with start=1, the block SHALL load outData<=inData, cnt<=shamt and mode<=arith, then go to SHIFT; with start=0 it SHALL stay in IDLE with outData unchanged.
REQ-014 SHIFT, cnt!=0: each edge SHALL shift outData right by 1, fill the MSB with the old MSB if mode=1 or with 0 if mode=0, and set cnt<=cnt-1.
REQ-015 SHIFT, cnt==0: the next edge SHALL go to DONE with outData unchanged.
REQ-016 DONE: done=1 for exactly one cycle; the next edge SHALL go to IDLE unconditionally.
REQ-017 Latency: with start sampled at edge E, done SHALL be high in the cycle following edge E+shamt+1 (shamt=0 gives done after E+1; shamt=31 gives done after E+32).
REQ-018 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE; both SHALL never be high together.
REQ-019 start in SHIFT or DONE SHALL be ignored with no queuing; inData, shamt and arith changes after acceptance SHALL have no effect.
REQ-020 start held high continuously SHALL launch a new operation on the first IDLE edge after DONE, with a minimum spacing of shamt+3 edges per operation.
REQ-021 Result SHALL equal inData>>shamt (logical) or $signed(inData)>>>shamt (arithmetic); no overflow or width growth is possible.
REQ-022 mode=1 with operand MSB=0 SHALL produce the same result as the logical shift.

Reset
REQ-023 rst=1 SHALL force IDLE, outData=0, cnt=0, mode=0, busy=0 and done=0 immediately, without waiting for clk.
REQ-024 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no done pulse; after rst deasserts, the first edge with start=1 SHALL be accepted.
REQ-025 After reset and before any start, outData SHALL read 0.

Verification
REQ-026 inData=32'd70, shamt=2, arith=0, start one cycle -> busy high for 3 cycles, then done pulse, outData=32'd17.
REQ-027 inData=32'h80000000, shamt=4 -> arith=1 gives outData=32'hF8000000; arith=0 gives outData=32'h08000000.
REQ-028 shamt=0, inData=32'h12345678 -> done after edge E+1, outData=32'h12345678.
REQ-029 inData=32'h80000000, shamt=31, arith=1 -> done after edge E+32, outData=32'hFFFFFFFF; with arith=0 -> outData=32'h00000001.
REQ-030 inData=32'd440 (110<<2), shamt=2, arith=0; during SHIFT drive start=1 with inData=32'hFFFFFFFF -> ignored, outData=32'd110, single done pulse.
REQ-031 Start shamt=10 and assert rst asynchronously between edges at cycle 5 -> outData=0, busy=0, done=0 at once, no done pulse; release rst and start shamt=1, inData=32'd12 -> outData=32'd6.
